// File: rtl/nibble_pkg.sv
// Shared constants and types for the nibble serializer.
package nibble_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage : nibble_pkg

// File: rtl/nibble_select.sv
// Combinational nibble picker: orders the word by emission order, then
// selects the beat addressed by k.
module nibble_select
    import nibble_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IDX_W     = 2
) (
    input  logic [WIDTH-1:0][NIBBLE_W-1:0] word,
    input  logic [IDX_W-1:0]               k,
    output logic [NIBBLE_W-1:0]            nib
);

    // ordered[i] is the nibble emitted on beat i
    logic [WIDTH-1:0][NIBBLE_W-1:0] ordered;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign ordered[gi] = word[WIDTH-1-gi];
            end else begin : g_lsb
                assign ordered[gi] = word[gi];
            end
        end
    endgenerate

    // Compare-based mux so indices beyond WIDTH-1 never address past the array
    always_comb begin
        nib = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (k == IDX_W'(i)) begin
                nib = ordered[i];
            end
        end
    end

endmodule : nibble_select

// File: rtl/nibble_serializer.sv
// Word-to-nibble serializer with valid/ready on both sides. A word is latched
// on accept and its nibbles stream out starting the following cycle; a new
// word can be taken on the last beat so consecutive words flow without gaps.
module nibble_serializer
    import nibble_pkg::*;
#(
    parameter int       WIDTH      = 4,
    parameter bit [3:0] IDLE_VALUE = 4'hF,
    parameter bit       MSB_FIRST  = 1'b0,
    localparam int      IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0][NIBBLE_W-1:0] in0,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NIBBLE_W-1:0]            out,
    output logic                           out_last,
    output logic [IDX_W-1:0]               out_index
);

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(WIDTH - 1);

    state_t                         state_q, state_d;
    logic [WIDTH-1:0][NIBBLE_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]               k_q, k_d;

    logic                           last_beat;
    logic [NIBBLE_W-1:0]            sel_nib;

    nibble_select #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_select (
        .word (word_q),
        .k    (k_q),
        .nib  (sel_nib)
    );

    assign last_beat = (state_q == SEND) && (k_q == LAST_K);

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        k_d       = k_q;
        out_valid = (state_q == SEND);
        out_last  = last_beat;
        out_index = k_q;
        out       = (state_q == SEND) ? sel_nib : NIBBLE_W'(IDLE_VALUE);
        in_ready  = (state_q == IDLE) || (last_beat && out_ready);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in0;
                    k_d     = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (last_beat) begin
                        // Take the next word on the final beat to avoid a bubble
                        k_d = '0;
                        if (in_valid) begin
                            word_d = in0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // State registers; reset overrides any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            word_q  <= word_d;
        end
    end

endmodule : nibble_serializer

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer: a table of per-cycle vectors for the
// LSB-first 4-nibble instance, plus short sequences for MSB-first and WIDTH=1.
module tb_nibble_serializer;

    typedef struct {
        logic        rst;
        logic        iv;
        logic        ordy;
        logic [15:0] din;
        logic        e_ov;
        logic [3:0]  e_out;
        logic        e_last;
        logic [1:0]  e_idx;
        logic        e_ir;
        logic        idx_en;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             iv;
    logic             ordy;
    logic [3:0][3:0]  din;
    logic [0:0][3:0]  din1;

    logic        ir_l, ov_l, last_l;
    logic [3:0]  out_l;
    logic [1:0]  idx_l;
    logic        ir_m, ov_m, last_m;
    logic [3:0]  out_m;
    logic [1:0]  idx_m;
    logic        ir_w, ov_w, last_w;
    logic [3:0]  out_w;
    logic [0:0]  idx_w;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    nibble_serializer #(.WIDTH(4), .IDLE_VALUE(4'hF), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir_l), .in0(din),
        .out_valid(ov_l), .out_ready(ordy), .out(out_l), .out_last(last_l),
        .out_index(idx_l)
    );

    nibble_serializer #(.WIDTH(4), .IDLE_VALUE(4'hF), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir_m), .in0(din),
        .out_valid(ov_m), .out_ready(ordy), .out(out_m), .out_last(last_m),
        .out_index(idx_m)
    );

    nibble_serializer #(.WIDTH(1), .IDLE_VALUE(4'hF), .MSB_FIRST(1'b0)) u_w1 (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir_w), .in0(din1),
        .out_valid(ov_w), .out_ready(ordy), .out(out_w), .out_last(last_w),
        .out_index(idx_w)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic rd, input logic [15:0] d,
                       input logic ov, input logic [3:0] o, input logic l,
                       input logic [1:0] ix, input logic ir, input logic ie);
        vec_t t;
        t.rst = r; t.iv = v; t.ordy = rd; t.din = d;
        t.e_ov = ov; t.e_out = o; t.e_last = l; t.e_idx = ix; t.e_ir = ir; t.idx_en = ie;
        tbl.push_back(t);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; ordy = 1'b1; din = '0; din1 = '0;
        next_cycle();
        next_cycle();

        // Post-reset idle state
        add(0,0,1,16'h0000, 0,4'hF,0,0,1,1);
        // LSB-first single word, out_ready held high
        add(0,1,1,16'h4321, 0,4'hF,0,0,1,0);
        add(0,0,1,16'h0000, 1,4'h1,0,0,0,1);
        add(0,0,1,16'h0000, 1,4'h2,0,1,0,1);
        add(0,0,1,16'h0000, 1,4'h3,0,2,0,1);
        add(0,0,1,16'h0000, 1,4'h4,1,3,1,1);
        add(0,0,1,16'h0000, 0,4'hF,0,0,1,0);
        // Backpressure holding nibble 2, then stall on the last beat
        add(0,1,1,16'h4321, 0,4'hF,0,0,1,0);
        add(0,0,1,16'h0000, 1,4'h1,0,0,0,1);
        add(0,0,0,16'h0000, 1,4'h2,0,1,0,1);
        add(0,0,0,16'h0000, 1,4'h2,0,1,0,1);
        add(0,0,0,16'h0000, 1,4'h2,0,1,0,1);
        add(0,0,1,16'h0000, 1,4'h2,0,1,0,1);
        add(0,0,1,16'h0000, 1,4'h3,0,2,0,1);
        add(0,0,0,16'h0000, 1,4'h4,1,3,0,1);
        add(0,0,1,16'h0000, 1,4'h4,1,3,1,1);
        add(0,0,1,16'h0000, 0,4'hF,0,0,1,0);
        // Back-to-back words; in0 scribbled while the second word is emitted
        add(0,1,1,16'h4321, 0,4'hF,0,0,1,0);
        add(0,1,1,16'h8765, 1,4'h1,0,0,0,1);
        add(0,1,1,16'h8765, 1,4'h2,0,1,0,1);
        add(0,1,1,16'h8765, 1,4'h3,0,2,0,1);
        add(0,1,1,16'h8765, 1,4'h4,1,3,1,1);
        add(0,0,1,16'hFFFF, 1,4'h5,0,0,0,1);
        add(0,0,1,16'h0000, 1,4'h6,0,1,0,1);
        add(0,0,1,16'hFFFF, 1,4'h7,0,2,0,1);
        add(0,0,1,16'h0000, 1,4'h8,1,3,1,1);
        add(0,0,1,16'h0000, 0,4'hF,0,0,1,0);
        // Reset mid-word with a competing in_valid, then a fresh word
        add(0,1,1,16'h4321, 0,4'hF,0,0,1,0);
        add(0,0,1,16'h0000, 1,4'h1,0,0,0,1);
        add(1,1,1,16'hAAAA, 1,4'h2,0,1,0,1);
        add(0,0,1,16'h0000, 0,4'hF,0,0,1,1);
        add(0,1,1,16'h8765, 0,4'hF,0,0,1,1);
        add(0,0,1,16'h0000, 1,4'h5,0,0,0,1);
        add(0,0,1,16'h0000, 1,4'h6,0,1,0,1);
        add(0,0,1,16'h0000, 1,4'h7,0,2,0,1);
        add(0,0,1,16'h0000, 1,4'h8,1,3,1,1);
        add(0,0,1,16'h0000, 0,4'hF,0,0,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; iv = tbl[i].iv; ordy = tbl[i].ordy; din = tbl[i].din;
            @(negedge clk);
            $display("row %0d: rst=%0b iv=%0b ordy=%0b din=%h -> ov=%0b out=%h last=%0b idx=%0d ir=%0b",
                     i, rst, iv, ordy, din, ov_l, out_l, last_l, idx_l, ir_l);
            chk($sformatf("row%0d_out_valid", i), 16'(ov_l), 16'(tbl[i].e_ov));
            chk($sformatf("row%0d_out", i), 16'(out_l), 16'(tbl[i].e_out));
            chk($sformatf("row%0d_out_last", i), 16'(last_l), 16'(tbl[i].e_last));
            chk($sformatf("row%0d_in_ready", i), 16'(ir_l), 16'(tbl[i].e_ir));
            if (tbl[i].idx_en)
                chk($sformatf("row%0d_out_index", i), 16'(idx_l), 16'(tbl[i].e_idx));
            next_cycle();
        end

        // MSB-first: 16'h4321 should come out 4,3,2,1
        rst = 1'b1; iv = 1'b0; ordy = 1'b1;
        next_cycle();
        rst = 1'b0; iv = 1'b1; din = 16'h4321;
        @(negedge clk);
        chk("msb_accept_ready", 16'(ir_m), 16'h1);
        next_cycle();
        iv = 1'b0; din = '0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            $display("msb beat %0d: ov=%0b out=%h last=%0b idx=%0d", b, ov_m, out_m, last_m, idx_m);
            chk($sformatf("msb_b%0d_out", b), 16'(out_m), 16'(4 - b));
            chk($sformatf("msb_b%0d_last", b), 16'(last_m), 16'(b == 3));
            chk($sformatf("msb_b%0d_index", b), 16'(idx_m), 16'(b));
            next_cycle();
        end
        @(negedge clk);
        chk("msb_idle_valid", 16'(ov_m), 16'h0);
        next_cycle();

        // WIDTH=1: each word is a single last beat; back-to-back A then B
        rst = 1'b1; iv = 1'b0; ordy = 1'b1;
        next_cycle();
        rst = 1'b0; iv = 1'b1; din1 = 4'hA;
        next_cycle();
        din1 = 4'hB;
        @(negedge clk);
        $display("w1 beat 0: ov=%0b out=%h last=%0b idx=%0d ir=%0b", ov_w, out_w, last_w, idx_w, ir_w);
        chk("w1_b0_valid", 16'(ov_w), 16'h1);
        chk("w1_b0_out", 16'(out_w), 16'hA);
        chk("w1_b0_last", 16'(last_w), 16'h1);
        chk("w1_b0_index", 16'(idx_w), 16'h0);
        chk("w1_b0_ready", 16'(ir_w), 16'h1);
        next_cycle();
        iv = 1'b0; din1 = 4'h0;
        @(negedge clk);
        $display("w1 beat 1: ov=%0b out=%h last=%0b idx=%0d", ov_w, out_w, last_w, idx_w);
        chk("w1_b1_out", 16'(out_w), 16'hB);
        chk("w1_b1_last", 16'(last_w), 16'h1);
        next_cycle();
        @(negedge clk);
        $display("w1 idle: ov=%0b out=%h", ov_w, out_w);
        chk("w1_idle_valid", 16'(ov_w), 16'h0);
        chk("w1_idle_out", 16'(out_w), 16'hF);
        chk("w1_idle_last", 16'(last_w), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nibble_serializer

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of 4-bit nibbles per input word, legal range 1..64.
REQ-002 SHALL have parameter [3:0] IDLE_VALUE, default 4'hF: value driven on out while out_valid is 0.
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 emits nibble 0 first, 1 emits nibble WIDTH-1 first.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: an input word is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-008 SHALL have port in0, input, [WIDTH-1:0][3:0] packed: the input word, nibble i at in0[i].
REQ-009 SHALL have port out_valid, output, 1 bit: a nibble is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer takes the nibble.
REQ-011 SHALL have port out, output, [3:0]: the current nibble.
REQ-012 SHALL have port out_last, output, 1 bit: the current nibble is the final beat of its word.
REQ-013 SHALL have port out_index, output, [IDX_W-1:0]: position of the current nibble in the word, IDX_W = max(1, clog2(WIDTH)).

Function
REQ-014 SHALL implement a two-state FSM, IDLE and SEND.
REQ-015 In IDLE: in_ready=1, out_valid=0, out=IDLE_VALUE, out_last=0.
REQ-016 In IDLE with in_valid=1: SHALL latch in0 into an internal register, clear the beat counter, and enter SEND.
REQ-017 The first nibble SHALL be valid exactly one cycle after the accept cycle; there is no combinational in0->out path.
REQ-018 In SEND: out_valid=1; out = word[k] when MSB_FIRST=0, out = word[WIDTH-1-k] when MSB_FIRST=1; out_index = k, where k is the beat counter.
REQ-019 out, out_last and out_index SHALL stay stable while out_valid=1 and out_ready=0 (backpressure).
REQ-020 On a beat with out_valid & out_ready and k < WIDTH-1: SHALL increment k.
REQ-021 out_last SHALL be 1 exactly when out_valid=1 and k == WIDTH-1.
REQ-022 On the last beat accepted (out_last & out_ready): if in_valid=1, SHALL accept the new word in that same cycle, reset k to 0 and stay in SEND; otherwise SHALL return to IDLE.
REQ-023 in_ready SHALL equal (state==IDLE) | (out_last & out_ready); this is the only combinational input-to-output path.
REQ-024 With back-to-back words, nibbles SHALL stream with no bubble cycle between words.
REQ-025 With WIDTH=1, every beat SHALL have out_last=1 and out_index=0.
REQ-026 in0 changes while in SEND SHALL have no effect on the nibbles already being emitted.

Reset
REQ-027 reset=1 at a rising clk edge SHALL force IDLE and k=0, giving out_valid=0, out=IDLE_VALUE, out_last=0, out_index=0, in_ready=1 in the following cycle.
REQ-028 Reset during SEND SHALL discard the word in flight; no further beats of it are emitted.
REQ-029 Reset SHALL take priority over every handshake event in the same cycle.

Structure
REQ-030 Package nibble_pkg SHALL hold NIBBLE_W=4 and the state enum typedef (IDLE, SEND).
REQ-031 The nibble select (word register, k, MSB_FIRST) -> out SHALL be a combinational sub-module, nibble_select.
REQ-032 All state elements SHALL be in the top module, clocked on clk.

Verification
REQ-033 WIDTH=4, MSB_FIRST=0, out_ready held 1, in0=16'h4321 accepted at cycle 0 -> out = 1, 2, 3, 4 in cycles 1-4; out_last=1 only in cycle 4; out_index = 0..3.
REQ-034 Same setup with MSB_FIRST=1 -> out = 4, 3, 2, 1.
REQ-035 out_ready=0 during cycles 2-4 -> out holds 2 with out_index=1 through cycle 4; the sequence resumes 3, 4 once out_ready returns to 1.
REQ-036 Words 16'h4321 and 16'h8765 back-to-back with in_valid held 1 -> out = 1,2,3,4,5,6,7,8 on eight consecutive cycles; in_ready=1 in the last-beat cycle of the first word.
REQ-037 Reset asserted while the beat with out=2 is presented -> next cycle out_valid=0, out=4'hF, in_ready=1; a following word starts again at out_index=0.
REQ-038 WIDTH=1, in0=4'hA -> a single beat out=A with out_last=1, then return to IDLE.
